n64_ctrl_responder: RTL and testbench

Controller-side end of the N64 joybus link. It emulates a standard controller on the single-wire data line. It decodes the 8-bit command the console sends, then answers 0x00/0xFF with a 24-bit status word and 0x01 with a 32-bit button word. All timing is derived from the 4 MHz system clock; the block sits behind an open-drain SB_IO pad with pull-up.

---
 rtl/n64_pkg.sv | 25 ++
 rtl/n64_resp_tx.sv | 86 ++++++++
 rtl/n64_ctrl_responder.sv | 210 +++++++++++++++++++++
 tb/tb_n64_ctrl_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared joybus constants: command codes, bit-timing landmarks and responder states.
package n64_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_READ   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [4:0] BIT_CYCLES  = 5'd16;
  localparam logic [4:0] SAMPLE_AT   = 5'd8;
  localparam logic [4:0] GLITCH_AT   = 5'd2;
  localparam logic [4:0] SHORT_LOW   = 5'd4;
  localparam logic [4:0] LONG_LOW    = 5'd12;
  localparam logic [4:0] TX_STOP_LOW = 5'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_BITS,
    ST_RX_STOP,
    ST_WAIT_HIGH,
    ST_TURNAROUND,
    ST_TX_BITS,
    ST_TX_STOP
  } state_t;

endpackage

// File: rtl/n64_resp_tx.sv
// Joybus reply serializer: MSB-first pulse-width bits followed by an 8-cycle low stop bit.
module n64_resp_tx
  import n64_pkg::*;
(
  input  logic        clk_4M,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] word,
  input  logic [5:0]  nbits,
  output logic        oe,
  output logic        done,
  output logic        in_stop
);

  logic [31:0] shift_q, shift_d;
  logic [5:0]  left_q, left_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic        stop_q, stop_d;
  logic        oe_q, oe_d;
  logic [4:0]  low_len;
  logic [4:0]  cnt_inc;

  always_comb begin
    low_len  = shift_q[31] ? SHORT_LOW : LONG_LOW;
    cnt_inc  = cnt_q + 5'd1;
    shift_d  = shift_q;
    left_d   = left_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    stop_d   = stop_q;
    oe_d     = oe_q;
    done     = 1'b0;
    if (start) begin
      shift_d  = word;
      left_d   = nbits;
      cnt_d    = '0;
      active_d = 1'b1;
      stop_d   = 1'b0;
      oe_d     = 1'b1;
    end else if (stop_q) begin
      // done is combinational so busy can drop on the same edge that releases the line
      if (cnt_q == TX_STOP_LOW - 5'd1) begin
        oe_d     = 1'b0;
        stop_d   = 1'b0;
        active_d = 1'b0;
        done     = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (active_q) begin
      if (cnt_q == BIT_CYCLES - 5'd1) begin
        shift_d = {shift_q[30:0], 1'b0};
        left_d  = left_q - 6'd1;
        cnt_d   = '0;
        oe_d    = 1'b1;
        if (left_q == 6'd1) stop_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
        oe_d  = (cnt_inc < low_len);
      end
    end
  end

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      left_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      stop_q   <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      left_q   <= left_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      stop_q   <= stop_d;
      oe_q     <= oe_d;
    end
  end

  assign oe      = oe_q;
  assign in_stop = stop_q;

endmodule

// File: rtl/n64_ctrl_responder.sv
// N64 controller emulation: receives the console command byte on the joybus line and replies.
module n64_ctrl_responder
  import n64_pkg::*;
#(
  parameter logic [23:0] STATUS_WORD = 24'h050002,
  parameter int unsigned REPLY_DELAY = 12,
  parameter int unsigned RX_TIMEOUT  = 32
) (
  input  logic        clk_4M,
  input  logic        rst_n,
  input  logic        din,
  output logic        dout,
  output logic        output_en,
  input  logic [31:0] buttons,
  output logic [7:0]  cmd,
  output logic        cmd_strobe,
  output logic        unknown_cmd,
  output logic        busy
);

  localparam logic [7:0] DLY_LAST = 8'(REPLY_DELAY - 2);
  localparam logic [7:0] TMO_LAST = 8'(RX_TIMEOUT - 1);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic        din_s, fall;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  dly_q, dly_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        in_bit_q, in_bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] reply_word_q, reply_word_d;
  logic [5:0]  reply_bits_q, reply_bits_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        strobe_q, strobe_d;
  logic        unknown_q, unknown_d;
  logic        busy_q, busy_d;
  logic        tx_start, tx_oe, tx_done, tx_in_stop;

  assign din_s = sync_q[1];
  assign fall  = prev_q & ~din_s;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    dly_d        = dly_q;
    bit_cnt_d    = bit_cnt_q;
    in_bit_d     = in_bit_q;
    shift_d      = shift_q;
    reply_word_d = reply_word_q;
    reply_bits_d = reply_bits_q;
    cmd_d        = cmd_q;
    strobe_d     = 1'b0;
    unknown_d    = 1'b0;
    busy_d       = busy_q;
    tx_start     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_RX_BITS;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          cnt_d     = 5'd1;
          tmo_d     = 8'd1;
          in_bit_d  = 1'b1;
        end
      end
      ST_RX_BITS, ST_RX_STOP: begin
        tmo_d = tmo_q + 8'd1;
        if (in_bit_q) cnt_d = cnt_q + 5'd1;
        if (fall) begin
          cnt_d    = 5'd1;
          tmo_d    = 8'd1;
          in_bit_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          in_bit_d = 1'b0;
        end else if (in_bit_q && cnt_q == GLITCH_AT && din_s) begin
          // A glitch on the very first edge means no frame has started at all
          in_bit_d = 1'b0;
          if (state_q == ST_RX_BITS && bit_cnt_q == 3'd0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else if (in_bit_q && cnt_q == SAMPLE_AT) begin
          in_bit_d = 1'b0;
          if (state_q == ST_RX_BITS) begin
            shift_d   = {shift_q[6:0], din_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_RX_STOP;
          end else if (din_s) begin
            cmd_d    = shift_q;
            strobe_d = 1'b1;
            case (shift_q)
              CMD_STATUS, CMD_RESET: begin
                reply_word_d = {STATUS_WORD, 8'h00};
                reply_bits_d = 6'd24;
                state_d      = ST_TURNAROUND;
                dly_d        = '0;
              end
              CMD_READ: begin
                reply_word_d = buttons;
                reply_bits_d = 6'd32;
                state_d      = ST_TURNAROUND;
                dly_d        = '0;
              end
              default: begin
                unknown_d = 1'b1;
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
              end
            endcase
          end else begin
            state_d = ST_WAIT_HIGH;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (din_s) begin
          if (cnt_q == BIT_CYCLES - 5'd1) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_TURNAROUND: begin
        dly_d = dly_q + 8'd1;
        if (dly_q == DLY_LAST) begin
          tx_start = 1'b1;
          state_d  = ST_TX_BITS;
        end
      end
      ST_TX_BITS: begin
        if (tx_in_stop) state_d = ST_TX_STOP;
      end
      ST_TX_STOP: begin
        if (tx_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      prev_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      dly_q        <= '0;
      bit_cnt_q    <= '0;
      in_bit_q     <= 1'b0;
      shift_q      <= '0;
      reply_word_q <= '0;
      reply_bits_q <= '0;
      cmd_q        <= '0;
      strobe_q     <= 1'b0;
      unknown_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], din};
      prev_q       <= din_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      dly_q        <= dly_d;
      bit_cnt_q    <= bit_cnt_d;
      in_bit_q     <= in_bit_d;
      shift_q      <= shift_d;
      reply_word_q <= reply_word_d;
      reply_bits_q <= reply_bits_d;
      cmd_q        <= cmd_d;
      strobe_q     <= strobe_d;
      unknown_q    <= unknown_d;
      busy_q       <= busy_d;
    end
  end

  n64_resp_tx u_tx (
    .clk_4M  (clk_4M),
    .rst_n   (rst_n),
    .start   (tx_start),
    .word    (reply_word_q),
    .nbits   (reply_bits_q),
    .oe      (tx_oe),
    .done    (tx_done),
    .in_stop (tx_in_stop)
  );

  assign dout        = 1'b0;
  assign output_en   = tx_oe;
  assign cmd         = cmd_q;
  assign cmd_strobe  = strobe_q;
  assign unknown_cmd = unknown_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_n64_ctrl_responder.sv
// Directed bench for n64_ctrl_responder: host-side frame driver plus reply decoder on output_en.
`timescale 1ns/1ps
module tb_n64_ctrl_responder;

  logic        clk_4M = 1'b0;
  logic        rst_n;
  logic        din;
  logic        dout;
  logic        output_en;
  logic [31:0] buttons;
  logic [7:0]  cmd;
  logic        cmd_strobe;
  logic        unknown_cmd;
  logic        busy;
  logic        host_low;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int unk_cnt = 0;

  // Open-drain line with pull-up: low if either side drives.
  assign din = ~(host_low | output_en);

  always #125 clk_4M = ~clk_4M;

  n64_ctrl_responder dut (
    .clk_4M      (clk_4M),
    .rst_n       (rst_n),
    .din         (din),
    .dout        (dout),
    .output_en   (output_en),
    .buttons     (buttons),
    .cmd         (cmd),
    .cmd_strobe  (cmd_strobe),
    .unknown_cmd (unknown_cmd),
    .busy        (busy)
  );

  always @(negedge clk_4M) begin
    if (cmd_strobe)  strobe_cnt++;
    if (unknown_cmd) unk_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_4M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    host_low = 1'b1;
    tick(v ? 4 : 12);
    host_low = 1'b0;
    tick(v ? 12 : 4);
  endtask

  // Returns 4 cycles after the host stop-bit falling edge, line released.
  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    host_low = 1'b1;
    tick(4);
    host_low = 1'b0;
  endtask

  task automatic wait_oe(output int cyc);
    cyc = 4;
    while (!output_en && cyc < 100) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic read_reply(input int nbits, output logic [31:0] word,
                            output int first_low, output int stop_low, output logic busy_end);
    int l, h;
    word = '0;
    first_low = 0;
    for (int b = 0; b < nbits; b++) begin
      l = 0;
      while (output_en && l < 40) begin l++; tick(1); end
      h = 0;
      while (!output_en && h < 40) begin h++; tick(1); end
      if (b == 0) first_low = l;
      word = {word[30:0], (l < 8)};
    end
    l = 0;
    while (output_en && l < 40) begin l++; tick(1); end
    stop_low = l;
    busy_end = busy;
  endtask

  initial begin
    int cyc, s0, u0, first_low, stop_low, oe_hits;
    logic [31:0] word;
    logic busy_end;

    rst_n = 1'b0;
    host_low = 1'b0;
    buttons = 32'h0;
    tick(3);
    check("rst_output_en", output_en, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd", cmd, 0);
    check("rst_strobe", cmd_strobe, 0);
    check("rst_unknown", unknown_cmd, 0);
    rst_n = 1'b1;
    tick(20);

    // 0x01 read: buttons change after latch must not affect the reply
    buttons = 32'h8000_1234;
    s0 = strobe_cnt;
    send_cmd(8'h01);
    wait_oe(cyc);
    buttons = 32'h0F0F_F0F0;
    check("read_delay", cyc, 22);
    check("read_strobe_cnt", strobe_cnt - s0, 1);
    check("read_cmd", cmd, 8'h01);
    check("read_busy_tx", busy, 1);
    read_reply(32, word, first_low, stop_low, busy_end);
    check("read_reply", word, 32'h8000_1234);
    check("read_first_low", first_low, 4);
    check("read_stop_low", stop_low, 8);
    check("read_busy_end", busy_end, 0);
    tick(20);

    // 0x00 status
    send_cmd(8'h00);
    wait_oe(cyc);
    read_reply(24, word, first_low, stop_low, busy_end);
    check("status_cmd", cmd, 8'h00);
    check("status_reply", word[23:0], 24'h050002);
    check("status_first_low", first_low, 12);
    check("status_stop_low", stop_low, 8);
    tick(20);

    // 0xFF reset gives the same reply
    send_cmd(8'hFF);
    wait_oe(cyc);
    check("reset_delay", cyc, 22);
    read_reply(24, word, first_low, stop_low, busy_end);
    check("reset_cmd", cmd, 8'hFF);
    check("reset_reply", word[23:0], 24'h050002);
    tick(20);

    // 0x42 unsupported: no reply
    u0 = unk_cnt;
    oe_hits = 0;
    send_cmd(8'h42);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (output_en) oe_hits++;
    end
    check("unk_pulse_cnt", unk_cnt - u0, 1);
    check("unk_oe_hits", oe_hits, 0);
    check("unk_busy", busy, 0);

    // 1-cycle glitch in IDLE, then a normal 0x01
    host_low = 1'b1;
    tick(1);
    host_low = 1'b0;
    tick(20);
    check("glitch_busy", busy, 0);
    buttons = 32'h1234_5678;
    s0 = strobe_cnt;
    u0 = unk_cnt;
    send_cmd(8'h01);
    wait_oe(cyc);
    check("glitch_delay", cyc, 22);
    read_reply(32, word, first_low, stop_low, busy_end);
    check("glitch_strobe_cnt", strobe_cnt - s0, 1);
    check("glitch_unk_cnt", unk_cnt - u0, 0);
    check("glitch_reply", word, 32'h1234_5678);
    tick(20);

    // Truncated frame: 5 bits, then silence; busy falls 32 cycles after synced edge
    s0 = strobe_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    host_low = 1'b1;
    cyc = 0;
    while (cyc < 60) begin
      tick(1);
      cyc++;
      if (cyc == 4) host_low = 1'b0;
      if (!busy) break;
    end
    host_low = 1'b0;
    check("trunc_busy_fall", cyc, 34);
    check("trunc_strobe_cnt", strobe_cnt - s0, 0);
    tick(5);
    send_cmd(8'h00);
    wait_oe(cyc);
    read_reply(24, word, first_low, stop_low, busy_end);
    check("trunc_next_reply", word[23:0], 24'h050002);
    tick(20);

    // Reset asserted during reply bit 10
    buttons = 32'hAAAA_5555;
    send_cmd(8'h01);
    wait_oe(cyc);
    tick(16 * 9 + 2);
    check("midtx_oe_before", output_en, 1);
    rst_n = 1'b0;
    #1;
    check("midtx_oe_async", output_en, 0);
    check("midtx_busy", busy, 0);
    check("midtx_cmd", cmd, 0);
    check("midtx_strobe", cmd_strobe, 0);
    check("midtx_unknown", unknown_cmd, 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    buttons = 32'h8000_1234;
    send_cmd(8'h01);
    wait_oe(cyc);
    check("after_rst_delay", cyc, 22);
    read_reply(32, word, first_low, stop_low, busy_end);
    check("after_rst_reply", word, 32'h8000_1234);
    check("after_rst_stop_low", stop_low, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
